memory_controller: RTL and testbench

//  Consumes hart_to_memory_controller requests (Load, Store, fetch) from NUM_CHANNELS requesters.

---
 rtl/memory_controller_pkg.sv | 18 +
 rtl/memory_bram.sv | 27 ++
 rtl/memory_controller.sv | 153 +++++++++++++++
 tb/tb_memory_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_controller_pkg.sv
// Shared types, constants and the address-fault helper for the memory controller slice.
package memory_controller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_LSB   = 2;

  // A request faults when it is not word aligned or lies beyond the end of memory.
  function automatic logic addr_error(input logic [31:0] address, input logic [31:0] capacity);
    return (address[ADDR_LSB-1:0] != '0) || (address >= capacity);
  endfunction

endpackage

// File: rtl/memory_bram.sv
// Single-port word BRAM with a registered read port (1-cycle latency, read-before-write).
module memory_bram
  import memory_controller_pkg::*;
#(
  parameter int CAPACITY_IN_BYTES = 4096,
  parameter int ADDR_WIDTH        = $clog2(CAPACITY_IN_BYTES / WORD_BYTES)
) (
  input  logic                  clock,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  write_enable,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data
);

  localparam int DEPTH = CAPACITY_IN_BYTES / WORD_BYTES;

  logic [31:0] mem [DEPTH];

  // Write the addressed word when enabled; always register the addressed word onto read_data.
  always_ff @(posedge clock) begin
    if (write_enable) begin
      mem[address] <= write_data;
    end
    read_data <= mem[address];
  end

endmodule

// File: rtl/memory_controller.sv
// Round-robin arbiter plus IDLE/ACCESS/RESPOND FSM in front of one single-port word BRAM.
//
// Handshake: a request transfers on a rising edge where req_valid[i] and req_ready[i] are
// both high; req_ready is only ever raised in IDLE, for the granted channel alone. A response
// transfers on a rising edge where rsp_valid[i] and rsp_ready[i] are both high; rsp_valid,
// rsp_read_data and rsp_error are held stable until that edge. One transaction is in flight.
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter int NUM_CHANNELS      = 2,
  parameter int CAPACITY_IN_BYTES = 4096
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic [NUM_CHANNELS-1:0]    req_valid,
  output logic [NUM_CHANNELS-1:0]    req_ready,
  input  logic [NUM_CHANNELS*32-1:0] req_address,
  input  logic [NUM_CHANNELS-1:0]    req_write,
  input  logic [NUM_CHANNELS*32-1:0] req_write_data,
  output logic [NUM_CHANNELS-1:0]    rsp_valid,
  input  logic [NUM_CHANNELS-1:0]    rsp_ready,
  output logic [NUM_CHANNELS*32-1:0] rsp_read_data,
  output logic [NUM_CHANNELS-1:0]    rsp_error,
  output state_t                     state_debug
);

  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int DEPTH = CAPACITY_IN_BYTES / WORD_BYTES;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);

  state_t            state;
  state_t            state_next;
  logic [CH_W-1:0]   last_grant;
  logic [CH_W-1:0]   grant;
  logic              grant_found;
  int                arb_idx;
  logic [31:0]       grant_address;
  logic              grant_err;

  logic [CH_W-1:0]   cur_ch;
  logic [AW-1:0]     cur_word;
  logic              cur_write;
  logic [31:0]       cur_wdata;
  logic              cur_err;

  logic              bram_we;
  logic [31:0]       bram_rdata;
  logic [31:0]       rsp_data;

  assign state_debug = state;

  // Round-robin search: first valid channel after last_grant, wrapping at NUM_CHANNELS.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    arb_idx     = 0;
    for (int k = 1; k <= NUM_CHANNELS; k++) begin
      arb_idx = int'(last_grant) + k;
      if (arb_idx >= NUM_CHANNELS) begin
        arb_idx = arb_idx - NUM_CHANNELS;
      end
      if (!grant_found && req_valid[CH_W'(arb_idx)]) begin
        grant       = CH_W'(arb_idx);
        grant_found = 1'b1;
      end
    end
  end

  assign grant_address = req_address[grant*32 +: 32];
  assign grant_err     = addr_error(grant_address, 32'(CAPACITY_IN_BYTES));

  // Writes and faulted requests return zero data; reads return the registered BRAM word.
  assign rsp_data = (cur_write || cur_err) ? 32'h0 : bram_rdata;

  // FSM state register.
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, handshake outputs and BRAM write enable.
  always_comb begin
    state_next    = state;
    req_ready     = '0;
    rsp_valid     = '0;
    rsp_read_data = '0;
    rsp_error     = '0;
    bram_we       = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant] = 1'b1;
          state_next       = ACCESS;
        end
      end
      ACCESS: begin
        bram_we    = cur_write && !cur_err;
        state_next = RESPOND;
      end
      RESPOND: begin
        rsp_valid[cur_ch]              = 1'b1;
        rsp_read_data[cur_ch*32 +: 32] = rsp_data;
        rsp_error[cur_ch]              = cur_err;
        if (rsp_ready[cur_ch]) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Remember who was served last so the next search starts just after it.
  always_ff @(posedge clock) begin
    if (clear) begin
      last_grant <= LAST_CH;
    end else if (state == RESPOND && rsp_ready[cur_ch]) begin
      last_grant <= cur_ch;
    end
  end

  // Capture the granted request; only the word index is kept since faults are decided here.
  always_ff @(posedge clock) begin
    if (clear) begin
      cur_ch    <= '0;
      cur_word  <= '0;
      cur_write <= 1'b0;
      cur_wdata <= '0;
      cur_err   <= 1'b0;
    end else if (state == IDLE && grant_found) begin
      cur_ch    <= grant;
      cur_word  <= grant_address[ADDR_LSB +: AW];
      cur_write <= req_write[grant];
      cur_wdata <= req_write_data[grant*32 +: 32];
      cur_err   <= grant_err;
    end
  end

  memory_bram #(
    .CAPACITY_IN_BYTES(CAPACITY_IN_BYTES),
    .ADDR_WIDTH       (AW)
  ) u_bram (
    .clock       (clock),
    .address     (cur_word),
    .write_enable(bram_we),
    .write_data  (cur_wdata),
    .read_data   (bram_rdata)
  );

endmodule

// File: tb/tb_memory_controller.sv
// Directed testbench for memory_controller with hand-computed expected values.
module tb_memory_controller;
  import memory_controller_pkg::*;

  localparam int N = 2;

  logic            clock = 1'b0;
  logic            clear;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_address;
  logic [N-1:0]    req_write;
  logic [N*32-1:0] req_write_data;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [N*32-1:0] rsp_read_data;
  logic [N-1:0]    rsp_error;
  state_t          state_debug;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  int          exp_ch_q[$];

  logic [31:0] t_data;
  logic        t_err;
  int          t_lat;
  int          g;
  int          done;
  int          ngrant;
  int          n;
  int          rr_k[N];
  logic [N-1:0] seen;

  memory_controller #(
    .NUM_CHANNELS     (N),
    .CAPACITY_IN_BYTES(4096)
  ) dut (
    .clock         (clock),
    .clear         (clear),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_address   (req_address),
    .req_write     (req_write),
    .req_write_data(req_write_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_read_data (rsp_read_data),
    .rsp_error     (rsp_error),
    .state_debug   (state_debug)
  );

  // Clock.
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a request on channel c, wait for acceptance, then capture its response.
  task automatic txn(input int c, input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e, output int lat);
    int k;
    @(negedge clock);
    req_valid[c]              = 1'b1;
    req_write[c]              = w;
    req_address[c*32 +: 32]    = a;
    req_write_data[c*32 +: 32] = d;
    #1;
    k = 0;
    while (!req_ready[c] && k < 20) begin
      @(negedge clock);
      #1;
      k++;
    end
    if (!req_ready[c]) check("accept_timeout", {31'b0, req_ready[c]}, 32'd1);
    @(posedge clock);
    #1;
    req_valid[c] = 1'b0;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!rsp_valid[c] && lat < 20);
    if (!rsp_valid[c]) check("rsp_timeout", {31'b0, rsp_valid[c]}, 32'd1);
    rd = rsp_read_data[c*32 +: 32];
    e  = rsp_error[c];
  endtask

  initial begin
    // Reset.
    clear          = 1'b1;
    req_valid      = '0;
    req_address    = '0;
    req_write      = '0;
    req_write_data = '0;
    rsp_ready      = '1;
    repeat (2) @(posedge clock);
    #1 clear = 1'b0;
    @(negedge clock);
    check("rst_rsp_valid", {30'b0, rsp_valid}, 32'd0);
    check("rst_req_ready", {30'b0, req_ready}, 32'd0);
    check("rst_state", {30'b0, state_debug}, {30'b0, IDLE});

    // Single write then read on channel 0.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, t_data, t_err, t_lat);
    check("wr_latency", t_lat, 32'd2);
    check("wr_err", {31'b0, t_err}, 32'd0);
    check("wr_data", t_data, 32'h0);
    txn(0, 1'b0, 32'h10, 32'h0, t_data, t_err, t_lat);
    check("rd_latency", t_lat, 32'd2);
    check("rd_err", {31'b0, t_err}, 32'd0);
    check("rd_data", t_data, 32'hDEADBEEF);

    // Unaligned write on channel 1 must fault and leave word 4 untouched.
    txn(1, 1'b1, 32'h13, 32'h11111111, t_data, t_err, t_lat);
    check("unal_err", {31'b0, t_err}, 32'd1);
    check("unal_data", t_data, 32'h0);
    txn(1, 1'b0, 32'h10, 32'h0, t_data, t_err, t_lat);
    check("unal_keep", t_data, 32'hDEADBEEF);

    // Out of range: faults, and a write there must not alias onto word 0.
    txn(0, 1'b1, 32'h0, 32'hCAFEF00D, t_data, t_err, t_lat);
    txn(0, 1'b0, 32'h1000, 32'h0, t_data, t_err, t_lat);
    check("oor_rd_err", {31'b0, t_err}, 32'd1);
    check("oor_rd_data", t_data, 32'h0);
    txn(1, 1'b1, 32'h1000, 32'h0BAD0BAD, t_data, t_err, t_lat);
    check("oor_wr_err", {31'b0, t_err}, 32'd1);
    txn(0, 1'b0, 32'h0, 32'h0, t_data, t_err, t_lat);
    check("oor_no_alias", t_data, 32'hCAFEF00D);

    // Preload words for round-robin and backpressure.
    txn(0, 1'b1, 32'h20, 32'hA0A0A0A0, t_data, t_err, t_lat);
    txn(1, 1'b1, 32'h24, 32'hA1A1A1A1, t_data, t_err, t_lat);
    txn(0, 1'b1, 32'h28, 32'hA2A2A2A2, t_data, t_err, t_lat);
    txn(1, 1'b1, 32'h2C, 32'hA3A3A3A3, t_data, t_err, t_lat);

    // Round-robin: reset, then both channels hold valid for two reads each.
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1 clear = 1'b0;
    exp_q    = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3};
    exp_ch_q = '{0, 1, 0, 1};
    req_write = '0;
    req_address[0 +: 32]  = 32'h20;
    req_address[32 +: 32] = 32'h24;
    rr_k[0] = 0;
    rr_k[1] = 0;
    req_valid = 2'b11;
    done   = 0;
    ngrant = 0;
    for (int cyc = 0; cyc < 60 && done < 4; cyc++) begin
      @(negedge clock);
      if (rsp_valid != '0) begin
        g = rsp_valid[1] ? 1 : 0;
        check("rr_rsp_ch", g, exp_ch_q[done]);
        check("rr_rsp_data", rsp_read_data[g*32 +: 32], exp_q.pop_front());
        done++;
      end
      if (req_ready != '0 && ngrant < 4) begin
        g = req_ready[1] ? 1 : 0;
        check("rr_grant", g, exp_ch_q[ngrant]);
        ngrant++;
        @(posedge clock);
        #1;
        rr_k[g]++;
        if (rr_k[g] >= 2) req_valid[g] = 1'b0;
        else req_address[g*32 +: 32] = 32'h20 + 32'(8 * rr_k[g]) + 32'(4 * g);
      end
    end
    check("rr_done", done, 32'd4);
    req_valid = '0;

    // Backpressure on channel 0 while channel 1 waits.
    @(negedge clock);
    rsp_ready[0]          = 1'b0;
    req_write             = '0;
    req_address[0 +: 32]  = 32'h20;
    req_valid[0]          = 1'b1;
    #1;
    n = 0;
    while (!req_ready[0] && n < 20) begin @(negedge clock); #1; n++; end
    @(posedge clock);
    #1;
    req_valid[0]          = 1'b0;
    req_address[32 +: 32] = 32'h24;
    req_valid[1]          = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!rsp_valid[0] && n < 20);
    check("bp_first_valid", {31'b0, rsp_valid[0]}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clock);
      check("bp_valid", {31'b0, rsp_valid[0]}, 32'd1);
      check("bp_data", rsp_read_data[0 +: 32], 32'hA0A0A0A0);
      check("bp_err", {31'b0, rsp_error[0]}, 32'd0);
      check("bp_req_ready", {30'b0, req_ready}, 32'd0);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clock);
    check("bp_release_idle", {30'b0, state_debug}, {30'b0, IDLE});
    check("bp_next_grant", {30'b0, req_ready}, 32'd2);
    @(posedge clock);
    #1 req_valid[1] = 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (!rsp_valid[1] && n < 20);
    check("bp_ch1_data", rsp_read_data[32 +: 32], 32'hA1A1A1A1);

    // Reset in the ACCESS state of a channel 1 read.
    @(negedge clock);
    req_address[32 +: 32] = 32'h10;
    req_valid[1]          = 1'b1;
    #1;
    n = 0;
    while (!req_ready[1] && n < 20) begin @(negedge clock); #1; n++; end
    @(posedge clock);
    #1;
    req_valid[1] = 1'b0;
    check("mid_in_access", {30'b0, state_debug}, {30'b0, ACCESS});
    clear = 1'b1;
    @(posedge clock);
    #1 clear = 1'b0;
    @(negedge clock);
    check("mid_rsp_valid", {30'b0, rsp_valid}, 32'd0);
    check("mid_rsp_data", rsp_read_data[63:32], 32'h0);
    check("mid_rsp_err", {30'b0, rsp_error}, 32'd0);
    check("mid_state", {30'b0, state_debug}, {30'b0, IDLE});
    seen = '0;
    repeat (4) begin @(negedge clock); seen = seen | rsp_valid; end
    check("mid_no_rsp", {30'b0, seen}, 32'd0);
    req_address[0 +: 32]  = 32'h10;
    req_address[32 +: 32] = 32'h24;
    req_valid             = 2'b11;
    #1;
    check("mid_ch0_first", {30'b0, req_ready}, 32'd1);
    @(posedge clock);
    #1 req_valid = '0;
    n = 0;
    do begin @(negedge clock); n++; end while (!rsp_valid[0] && n < 20);
    check("mid_retained", rsp_read_data[0 +: 32], 32'hDEADBEEF);
    check("mid_retained_err", {31'b0, rsp_error[0]}, 32'd0);
    repeat (2) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
